// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV64M multiply/divide unit with valid/ready handshake.
// Define MULDIV_FAST_MUL_EN to compute multiplies with a single-cycle combinational multiplier.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            op_w,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     counter;
    logic [2:0]        op_q;
    logic              w_q;
    logic              neg_q;
    // Multiply: acc = product, mcand shifts left, mplier shifts right.
    // Divide: acc = remainder, mcand = divisor, mplier = dividend shifting into quotient.
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = '0;
        r[31:0] = v;
        return r;
    endfunction

    logic            is_mulh, w_in, sgn1, sgn2, s1, s2, neg_in;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] x1, x2, m1, m2, spec_val;

    always_comb begin
        is_mulh  = !op[2] && (op[1:0] != 2'b00);
        w_in     = (XLEN == 64) && op_w && !is_mulh;
        sgn1     = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        sgn2     = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        x1       = w_in ? zext32(op1[31:0]) : op1;
        x2       = w_in ? zext32(op2[31:0]) : op2;
        s1       = sgn1 && (w_in ? op1[31] : op1[XLEN-1]);
        s2       = sgn2 && (w_in ? op2[31] : op2[XLEN-1]);
        m1       = s1 ? -x1 : x1;
        m2       = s2 ? -x2 : x2;
        if (w_in) begin
            m1 = zext32(m1[31:0]);
            m2 = zext32(m2[31:0]);
        end
        case (op)
            3'b001, 3'b100: neg_in = s1 ^ s2;
            3'b010, 3'b110: neg_in = s1;
            default:        neg_in = 1'b0;
        endcase
        div_zero = w_in ? (op2[31:0] == 32'd0) : (op2 == '0);
        div_ovf  = !op[0] && (w_in ? (op1[31:0] == 32'h8000_0000 && op2[31:0] == 32'hFFFF_FFFF)
                                   : (op1 == MOST_NEG && op2 == '1));
        special  = op[2] && (div_zero || div_ovf);
        if (div_zero)
            spec_val = op[1] ? (w_in ? sext32(op1[31:0]) : op1) : '1;
        else
            spec_val = op[1] ? '0 : (w_in ? sext32(32'h8000_0000) : MOST_NEG);
    end

    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, fix_val;

    always_comb begin
        rem_sh   = {acc[XLEN-1:0], mplier[XLEN-1]};
        rem_ge   = rem_sh >= {1'b0, mcand[XLEN-1:0]};
        rem_nxt  = rem_ge ? XLEN'(rem_sh - {1'b0, mcand[XLEN-1:0]}) : rem_sh[XLEN-1:0];
        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -mplier : mplier;
        r_fix    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        case (op_q)
            3'b000:                 fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = q_fix;
            default:                fix_val = r_fix;
        endcase
        if (w_q)
            fix_val = sext32(fix_val[31:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            counter   <= '0;
            op_q      <= '0;
            w_q       <= 1'b0;
            neg_q     <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            counter   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q     <= op;
                    w_q      <= w_in;
                    neg_q    <= neg_in;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    acc      <= '0;
                    if (special) begin
                        state  <= DONE;
                        result <= spec_val;
                    end else begin
                        state   <= CALC;
                        counter <= w_in ? CW'(32) : CW'(XLEN);
                        if (op[2]) begin
                            mcand  <= {{XLEN{1'b0}}, m2};
                            mplier <= w_in ? (m1 << (XLEN - 32)) : m1;
                        end else begin
                            mcand  <= {{XLEN{1'b0}}, m1};
                            mplier <= m2;
                        end
                    end
                end
                CALC: begin
                    if (counter == '0) begin
                        state <= FIX;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        if (!op_q[2]) begin
                            acc     <= mcand * {{XLEN{1'b0}}, mplier};
                            counter <= '0;
                        end else begin
                            counter <= counter - CW'(1);
                            acc     <= {{XLEN{1'b0}}, rem_nxt};
                            mplier  <= {mplier[XLEN-2:0], rem_ge};
                        end
`else
                        counter <= counter - CW'(1);
                        if (!op_q[2]) begin
                            if (mplier[0])
                                acc <= acc + mcand;
                            mcand  <= mcand << 1;
                            mplier <= mplier >> 1;
                        end else begin
                            acc    <= {{XLEN{1'b0}}, rem_nxt};
                            mplier <= {mplier[XLEN-2:0], rem_ge};
                        end
`endif
                    end
                end
                FIX: begin
                    result    <= fix_val;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    // Special-case accepts arrive here with out_valid still low.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MNEG = 64'h8000_0000_0000_0000;
`ifdef MULDIV_FAST_MUL_EN
    localparam int ML  = 3;
    localparam int MLW = 3;
`else
    localparam int ML  = 66;
    localparam int MLW = 34;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic        op_w = 1'b0;
    logic [63:0] op1 = '0;
    logic [63:0] op2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    muldiv_unit #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op_w(op_w), .op1(op1), .op2(op2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        op = o; op_w = w; op1 = a; op2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat);
        int cyc;
        issue(o, w, a, b);
        chk({tag, " busy"}, {63'd0, busy}, 64'd1);
        wait_valid(cyc);
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " result"}, result, exp);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " drained"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    initial begin
        int cyc;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset out_valid/busy", {62'd0, out_valid, busy}, 64'd0);
        chk("reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run("MUL", 3'b000, 1'b0, 64'd10, 64'd15, 64'd150, ML);
        run("MULH", 3'b001, 1'b0, ONES, ONES, 64'd0, ML);
        run("MULHU", 3'b011, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, ML);
        run("MULHSU", 3'b010, 1'b0, ONES, 64'd2, ONES, ML);
        run("DIV", 3'b100, 1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66);
        run("REM", 3'b110, 1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run("DIVU", 3'b101, 1'b0, 64'd20, 64'd3, 64'd6, 66);
        run("REMU", 3'b111, 1'b0, 64'd20, 64'd3, 64'd2, 66);
        run("DIVU0", 3'b101, 1'b0, 64'd7, 64'd0, ONES, 1);
        run("REMU0", 3'b111, 1'b0, 64'd7, 64'd0, 64'd7, 1);
        run("DIVOVF", 3'b100, 1'b0, MNEG, ONES, MNEG, 1);
        run("REMOVF", 3'b110, 1'b0, MNEG, ONES, 64'd0, 1);
        run("DIVW", 3'b100, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'd5, 64'hFFFF_FFFF_FFFF_FFFC, 34);
        run("REMW", 3'b110, 1'b1, 64'hABCD_0000_FFFF_FFEC, 64'hFFFF_0000_0000_0003,
            64'hFFFF_FFFF_FFFF_FFFE, 34);
        run("MULW", 3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MLW);
        run("DIVWOVF", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 1);
        run("REMUW0", 3'b111, 1'b1, 64'h0000_0001_8000_0007, 64'h0000_0005_0000_0000,
            64'hFFFF_FFFF_8000_0007, 1);

        // Result held while the consumer stalls.
        issue(3'b101, 1'b0, 64'd20, 64'd3);
        wait_valid(cyc);
        chk("hold latency", 64'(cyc), 64'd66);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold result", result, 64'd6);
            chk("hold flags", {62'd0, out_valid, in_ready}, 64'b10);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold drained", {62'd0, out_valid, in_ready}, 64'b01);

        // Flush in CALC.
        issue(3'b000, 1'b0, 64'd10, 64'd15);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush state", {61'd0, out_valid, busy, in_ready}, 64'b001);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush no out_valid", {63'd0, seen}, 64'd0);

        // Flush wins over in_valid in IDLE.
        @(negedge clk);
        op = 3'b000; op_w = 1'b0; op1 = 64'd2; op2 = 64'd2;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush+in_valid", {62'd0, busy, in_ready}, 64'b01);
        repeat (5) @(posedge clk);
        #1;
        chk("flush+in_valid quiet", {62'd0, out_valid, busy}, 64'd0);

        run("MUL post-flush", 3'b000, 1'b0, 64'd3, 64'd4, 64'd12, ML);

        // Asynchronous reset mid-CALC.
        issue(3'b101, 1'b0, 64'd20, 64'd3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst mid-op flags", {61'd0, out_valid, busy, in_ready}, 64'b001);
        chk("rst mid-op result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run("DIVU post-rst", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 66);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
